rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters. It produces a registered one-hot grant plus the 3-bit encoded index of the owner, so downstream muxes can be steered by the index. It enforces a bus-turnaround gap between owners and an optional maximum hold time with preemption. It sits in front of any shared datapath whose select input is driven by an 8-to-3 encoded owner index.

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_arbiter8_if.sv | 14 +
 rtl/rr_pick8.sv | 27 ++
 rtl/rr_arbiter8.sv | 102 ++++++++++
 tb/tb_rr_arbiter8.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package arb_pkg;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             preempt;
  logic [IDX_W-1:0] last_idx;

  modport master (output req, input gnt, gnt_idx, gnt_valid, preempt, last_idx);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt, last_idx);
endinterface

// File: rtl/rr_pick8.sv
// Combinational rotated-priority pick: first set request after last_idx, wrapping mod 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);
  logic [IDX_W-1:0]   off;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;

  // Rotate so the slot after the last owner sits at bit 0, encode lowest set bit, undo rotation.
  always_comb begin
    off = last_idx + IDX_W'(1);
    dbl = {req, req} >> off;
    rot = dbl[N_REQ-1:0];
    enc = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    any     = |req;
    win_idx = enc + off;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with turnaround gap and optional hold-time preemption.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter8_if.slave  bus
);
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_any_c;
  logic [IDX_W-1:0] pick_idx_c;

  rr_pick8 u_pick (
    .req      (bus.req),
    .last_idx (last_q),
    .any      (pick_any_c),
    .win_idx  (pick_idx_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      last_q    <= IDX_W'(N_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and next-output logic; preempt is a pulse so it defaults low.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          gnt_d   = N_REQ'(1) << pick_idx_c;
          idx_d   = pick_idx_c;
          last_d  = pick_idx_c;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // A release on the timeout edge wins over preemption.
        if (!bus.req[idx_q]) begin
          gnt_d   = '0;
          valid_d = 1'b0;
          state_d = ST_GAP;
        end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
          gnt_d     = '0;
          valid_d   = 1'b0;
          preempt_d = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.last_idx  = last_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: two instances (MAX_HOLD=4 and MAX_HOLD=0) against a tenure-level model.
module tb_rr_arbiter8;
  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  int checks = 0;
  int errors = 0;

  rr_arbiter8_if if0 ();
  rr_arbiter8_if if1 ();
  assign if0.req = req;
  assign if1.req = req;

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rr_arbiter8 #(.MAX_HOLD(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner (-1 = none), cycles granted so far, gap flag, pointer, last index, preempt flag.
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_idx[2];
  bit m_gap[2];
  bit m_pre[2];
  int m_max[2] = '{4, 0};

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_held[d] = 0; m_ptr[d] = 7;
      m_idx[d] = 0; m_gap[d] = 1'b0; m_pre[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    bit found;
    if (m_gap[d]) begin
      m_gap[d] = 1'b0;
      m_pre[d] = 1'b0;
    end else if (m_owner[d] < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        if (!found && req[(m_ptr[d] + k) % 8]) begin
          found = 1'b1;
          m_owner[d] = (m_ptr[d] + k) % 8;
        end
      end
      if (found) begin
        m_ptr[d]  = m_owner[d];
        m_idx[d]  = m_owner[d];
        m_held[d] = 1;
      end
    end else if (!req[m_owner[d]]) begin
      m_owner[d] = -1; m_gap[d] = 1'b1; m_pre[d] = 1'b0;
    end else if (m_max[d] != 0 && m_held[d] == m_max[d]) begin
      m_owner[d] = -1; m_gap[d] = 1'b1; m_pre[d] = 1'b1;
    end else if (m_held[d] < 1000) begin
      m_held[d]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int d = 0; d < 2; d++) model_step(d);
  end

  function automatic logic [7:0] e_gnt(input int d);
    return (m_owner[d] < 0) ? 8'h00 : (8'h01 << m_owner[d]);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal expectation pinned against both the DUT and the model.
  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] mdl,
                     input logic [7:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  task automatic cmp(input int d, input logic [7:0] g, input logic [2:0] i, input logic v,
                     input logic p, input logic [2:0] l);
    chk($sformatf("gnt%0d", d), g, e_gnt(d));
    chk($sformatf("gnt_idx%0d", d), 8'(i), 8'(m_idx[d]));
    chk($sformatf("gnt_valid%0d", d), 8'(v), 8'(m_owner[d] >= 0));
    chk($sformatf("preempt%0d", d), 8'(p), 8'(m_pre[d]));
    chk($sformatf("last_idx%0d", d), 8'(l), 8'(m_ptr[d]));
    chk($sformatf("onehot%0d", d), 8'($onehot0(g)), 8'd1);
    chk($sformatf("valid_or%0d", d), 8'(v), 8'(|g));
  endtask

  always @(negedge clk) begin
    cmp(0, if0.gnt, if0.gnt_idx, if0.gnt_valid, if0.preempt, if0.last_idx);
    cmp(1, if1.gnt, if1.gnt_idx, if1.gnt_valid, if1.preempt, if1.last_idx);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (!if0.gnt_valid && n < 50) begin
      cyc();
      n++;
    end
    if (!if0.gnt_valid) chk({name, "_timeout"}, 8'd0, 8'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int z;
    int o;
    req   = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    lit("rst_gnt", if0.gnt, e_gnt(0), 8'h00);
    lit("rst_idx", 8'(if0.gnt_idx), 8'(m_idx[0]), 8'd0);
    lit("rst_last", 8'(if0.last_idx), 8'(m_ptr[0]), 8'd7);

    // First arbitration favours 0, then 7 after a two-cycle gap.
    req = 8'h81;
    cyc();
    lit("first_gnt", if0.gnt, e_gnt(0), 8'h01);
    lit("first_idx", 8'(if0.gnt_idx), 8'(m_idx[0]), 8'd0);
    req = 8'h80;
    cyc();
    lit("gap1_gnt", if0.gnt, e_gnt(0), 8'h00);
    cyc();
    lit("gap2_gnt", if0.gnt, e_gnt(0), 8'h00);
    cyc();
    lit("second_gnt", if0.gnt, e_gnt(0), 8'h80);
    lit("second_idx", 8'(if0.gnt_idx), 8'(m_idx[0]), 8'd7);
    req = 8'h00;
    repeat (4) cyc();

    // Full rotation with three-cycle tenures.
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      wait_grant("rot");
      o = k % 8;
      lit($sformatf("rot_idx%0d", k), 8'(if0.gnt_idx), 8'(m_idx[0]), 8'(o));
      cyc();
      cyc();
      req[o] = 1'b0;
      cyc();
      lit("rot_rel", if0.gnt, e_gnt(0), 8'h00);
      req[o] = 1'b1;
      z = 1;
      for (int n = 0; n < 10 && !if0.gnt_valid; n++) begin
        cyc();
        if (!if0.gnt_valid) z++;
      end
      chk("rot_gap_len", 8'(z), 8'd2);
    end
    req = 8'h00;
    repeat (5) cyc();

    // Preemption after exactly four cycles, then regrant; then handoff to 3.
    req = 8'h04;
    wait_grant("pre");
    lit("pre_gnt0", if0.gnt, e_gnt(0), 8'h04);
    for (int n = 1; n < 4; n++) begin
      cyc();
      lit($sformatf("pre_gnt%0d", n), if0.gnt, e_gnt(0), 8'h04);
    end
    cyc();
    lit("pre_cut_gnt", if0.gnt, e_gnt(0), 8'h00);
    lit("pre_pulse", 8'(if0.preempt), 8'(m_pre[0]), 8'd1);
    cyc();
    lit("pre_idle_gnt", if0.gnt, e_gnt(0), 8'h00);
    lit("pre_pulse_end", 8'(if0.preempt), 8'(m_pre[0]), 8'd0);
    cyc();
    lit("pre_regnt", if0.gnt, e_gnt(0), 8'h04);
    req = 8'h0C;
    repeat (4) cyc();
    lit("pre2_pulse", 8'(if0.preempt), 8'(m_pre[0]), 8'd1);
    cyc();
    cyc();
    lit("pre2_gnt", if0.gnt, e_gnt(0), 8'h08);
    lit("pre2_idx", 8'(if0.gnt_idx), 8'(m_idx[0]), 8'd3);
    req = 8'h00;
    repeat (4) cyc();

    // Release on the timeout edge counts as a normal release.
    req = 8'h04;
    wait_grant("sim");
    repeat (3) cyc();
    req = 8'h00;
    cyc();
    lit("sim_gnt", if0.gnt, e_gnt(0), 8'h00);
    lit("sim_preempt", 8'(if0.preempt), 8'(m_pre[0]), 8'd0);
    repeat (3) cyc();

    // Asynchronous reset in the middle of a tenure.
    req = 8'h20;
    wait_grant("ar");
    cyc();
    rst_n = 1'b0;
    #1;
    lit("ar_gnt", if0.gnt, e_gnt(0), 8'h00);
    lit("ar_valid", 8'(if0.gnt_valid), 8'(m_owner[0] >= 0), 8'd0);
    lit("ar_last", 8'(if0.last_idx), 8'(m_ptr[0]), 8'd7);
    #1 rst_n = 1'b1;
    req = 8'h21;
    wait_grant("ar2");
    lit("ar_regnt_idx", 8'(if0.gnt_idx), 8'(m_idx[0]), 8'd0);
    req = 8'h00;
    repeat (4) cyc();

    // Randomized traffic with sticky requests and occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      for (int b = 0; b < 8; b++) begin
        if (req[b]) req[b] = ($urandom_range(0, 9) != 0);
        else        req[b] = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
